tap_mult_scheduler: RTL

//  Round-robin scheduler that time-shares the single mult_out adder/multiplier tree among NUM_CH
//  tap-delay-line channels (input_ctrl instances). It replaces the free-running slot counter.

---
 rtl/tap_mult_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/tap_mult_scheduler.sv
// Purpose : round-robin arbiter time-sharing one mult_out tree among NUM_CH tap-delay-line channels.
// Latency : grant -> res_valid/ack after MULT_LAT+1 enabled edges; one result per MULT_LAT+1 cycles.
// Backpr. : clk_enable=0 freezes everything (ack/res_valid forced low); req is held until ack.
//
// Ports:
//   clk, reset (async active-low), clk_enable (global advance enable)
//   req[NUM_CH]          level requests, held by the channel until its ack
//   ack[NUM_CH]          one-cycle pulse to the channel whose result was captured (its shift enable)
//   sel, sel_valid       tapsum mux select of the current winner and its liveness
//   mult_filter_out      result from the shared tree, MULT_LAT cycles after sel changes
//   res_data, res_ch     captured result and the channel it belongs to
//   res_valid            one-cycle pulse qualifying res_data/res_ch
//   busy                 an operation is in flight
module tap_mult_scheduler #(
    parameter int NUM_CH   = 6,
    parameter int CH_W     = 3,
    parameter int DATA_W   = 10,
    parameter int MULT_LAT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] ack,
    output logic [CH_W-1:0]   sel,
    output logic              sel_valid,
    input  logic [DATA_W-1:0] mult_filter_out,
    output logic [DATA_W-1:0] res_data,
    output logic [CH_W-1:0]   res_ch,
    output logic              res_valid,
    output logic              busy
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state, state_d;
    logic [2:0]        cnt;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   winner;
    logic [NUM_CH-1:0] sel_oh;
    logic [NUM_CH-1:0] elig;
    logic              any_elig;
    logic              capture;
    logic              grant;

    assign sel_oh = NUM_CH'(1) << sel;

    // The result due this edge must count as already served, otherwise a
    // channel whose req is still up would be regranted the same slot it just got.
    // A channel seeing its ack high is likewise on its way down and ignored.
    always_comb begin
        elig = req & ~ack;
        if (state == RUN && cnt == 3'(MULT_LAT)) begin
            elig = elig & ~sel_oh;
        end
    end

    // Round-robin search starting just above the last winner, wrapping at NUM_CH-1.
    always_comb begin
        logic [CH_W-1:0] idx;
        winner   = '0;
        any_elig = 1'b0;
        idx      = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            if (!any_elig && elig[idx]) begin
                any_elig = 1'b1;
                winner   = idx;
            end
        end
    end

    // Next-state logic: nothing moves while clk_enable is low.
    always_comb begin
        state_d = state;
        capture = 1'b0;
        grant   = 1'b0;
        if (clk_enable) begin
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        grant   = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (cnt == 3'(MULT_LAT)) begin
                        capture = 1'b1;
                        if (any_elig) begin
                            grant = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            rr_ptr    <= CH_W'(NUM_CH - 1);
            sel       <= '0;
            sel_valid <= 1'b0;
            res_data  <= '0;
            res_ch    <= '0;
            res_valid <= 1'b0;
            ack       <= '0;
        end else begin
            ack       <= '0;
            res_valid <= 1'b0;
            if (capture) begin
                res_data  <= mult_filter_out;
                res_ch    <= sel;
                res_valid <= 1'b1;
                ack       <= sel_oh;
            end
            if (grant) begin
                sel       <= winner;
                sel_valid <= 1'b1;
                rr_ptr    <= winner;
                cnt       <= '0;
            end else if (capture) begin
                // Going idle: sel is left pointing at the last channel.
                sel_valid <= 1'b0;
            end else if (clk_enable && state == RUN) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

    assign busy = (state == RUN);

endmodule
